mmu_perm_ad_unit: RTL
=====================

Name: mmu_perm_ad_unit

Overview:
- Sequential successor to the combinational SV32 permission check.
- Accepts one leaf-PTE translation check per handshake and evaluates R/W/X/U/MXR/SUM permissions.
- Manages Accessed/Dirty bits in one of two modes: software-managed (fault when A/D must change) or hardware-managed (issues a PTE write-back on a memory port with timeout, then responds).
- Sits between the PTW/TLB refill path and the LSU/IFU fault logic; parametrised for SV32 and SV39 PTE/PA widths.

Parameters:
- PTE_W, 32, PTE width (32 = SV32, 64 = SV39); flag bits always at [7:0] = D,A,G,U,X,W,R,V.
- PA_W, 34, physical address width of the PTE location.
- USE_HW_SET_AD, 1'b0, 0 = software A/D (fault), 1 = hardware A/D write-back.
- TIMEOUT, 255, maximum WAIT_ACK cycles before declaring a bus fault; must be at least 1; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  1  check request valid
- req_ready_o  out  1  high only in IDLE
- req_user_i  in  1  1 = U-mode access
- req_acc_i  in  2  0 = LOAD, 1 = STORE, 2 = FETCH, 3 = illegal
- req_mxr_i  in  1  mstatus.MXR
- req_sum_i  in  1  mstatus.SUM
- req_pte_i  in  PTE_W  leaf PTE
- req_pte_addr_i  in  PA_W  physical address of the PTE
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_allow_o  out  1  access permitted
- rsp_fault_o  out  4  fault code (0 = none)
- rsp_pte_o  out  PTE_W  PTE after any A/D update
- mem_req_valid_o  out  1  PTE write request
- mem_req_ready_i  in  1  memory accepts the write
- mem_addr_o  out  PA_W  = latched req_pte_addr_i
- mem_wdata_o  out  PTE_W  updated PTE
- mem_rsp_valid_i  in  1  write completion
- mem_rsp_err_i  in  1  write error, qualified by mem_rsp_valid_i

Behaviour:
- Reset: FSM enters IDLE.
  - req_ready_o = 1.
  - rsp_valid_o, rsp_allow_o, and mem_req_valid_o are 0.
  - rsp_fault_o = 0; rsp_pte_o and mem_wdata_o = 0.
  - Timeout counter = 0.
- Reset mid-operation aborts everything; an outstanding write is abandoned and its late completion is ignored.
- States: IDLE, CHECK, WRITE, WAIT_ACK, RESP.
- IDLE: on req_valid_i && req_ready_o, latch all req_* fields and go to CHECK.
- CHECK (exactly one cycle) evaluates faults in this priority order; the first match wins:
  - 8: acc == 3.
  - 1: V = 0, or W & !R, or R = X = 0.
  - 2: user access with U = 0; or supervisor access with U = 1 and (acc == FETCH or !SUM).
  - 3: LOAD without (R | (MXR & X)).
  - 4: STORE without W.
  - 5: FETCH without X.
- A/D rule, applied only if no permission fault:
  - needA = !A; needD = (acc == STORE) & !D.
  - If neither is needed: allow, go to RESP.
  - SW mode with need: fault 6, allow = 0, go to RESP.
  - HW mode with need: form the new PTE with A = 1 and D |= (acc == STORE), go to WRITE.
- Faulting responses return the PTE unchanged.
- WRITE: mem_req_valid_o = 1; mem_addr_o and mem_wdata_o stay stable until mem_req_ready_i, then go to WAIT_ACK and clear the counter.
- WAIT_ACK: mem_rsp_valid_i is sampled only in this state; the counter increments each cycle.
  - Response without error: allow = 1, rsp_pte_o = new PTE.
  - Response with error: fault 7, allow = 0.
  - Counter reaches TIMEOUT with no response: fault 7, allow = 0.
  - A response in the same cycle as the timeout wins over the timeout.
  - All three cases go to RESP.
- RESP: rsp_valid_o = 1 with outputs stable until rsp_ready_i; return to IDLE on the handshake.
- Responses are never dropped; there is no back-to-back overlap, so throughput is at most 1 check per 3 cycles.
- Latency: rsp_valid_o rises 2 cycles after the accept edge with no write, or 4 + memory-wait cycles with a write.
- Stray mem_rsp_valid_i outside WAIT_ACK is ignored.

Test Plan:
- SV32, S-mode LOAD, PTE = 0x000000C3 (V,R,A,D) → rsp 2 cycles after accept: allow = 1, fault = 0, rsp_pte = 0xC3, no memory request.
- U-mode FETCH, PTE = 0x59 (V,X,U,A) → allow = 1; same PTE in S-mode with SUM = 1 → fault 2.
- SW mode, STORE, PTE = 0x47 (V,R,W,A, D = 0) → fault 6, allow = 0, mem_req_valid_o never asserted.
- HW mode, STORE, PTE = 0x07 at address 0x3_0000_1000:
  - Hold mem_req_ready_i low 3 cycles → mem_addr_o = 0x300001000 and mem_wdata_o = 0xC7 stay stable throughout.
  - Ack 2 cycles later → allow = 1, rsp_pte = 0xC7.
- HW mode, TIMEOUT = 4, no mem response → fault 7 after 4 WAIT_ACK cycles; a late ack in IDLE has no effect. Repeat with mem_rsp_err_i = 1 → fault 7.
- Priority and reset:
  - acc = 3 with V = 0 → fault 8.
  - LOAD with MXR = 1 and PTE = 0x49 (V,X,A) → allow = 1.
  - Assert rst_n low during WRITE → mem_req_valid_o drops immediately and req_ready_o = 1 after release.

Source files
------------

// File: rtl/mmu_perm_ad_unit.sv
`default_nettype none
// ============================================================================
// Module   : mmu_perm_ad_unit
// Brief    : Sequential leaf-PTE permission check with software or hardware
//            managed Accessed/Dirty bits (PTE write-back with timeout).
// Revision : 1.0 - initial release
// ============================================================================
module mmu_perm_ad_unit #(
    parameter int PTE_W         = 32,
    parameter int PA_W          = 34,
    parameter bit USE_HW_SET_AD = 1'b0,
    parameter int TIMEOUT       = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_user_i,
    input  logic [1:0]       req_acc_i,
    input  logic             req_mxr_i,
    input  logic             req_sum_i,
    input  logic [PTE_W-1:0] req_pte_i,
    input  logic [PA_W-1:0]  req_pte_addr_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_allow_o,
    output logic [3:0]       rsp_fault_o,
    output logic [PTE_W-1:0] rsp_pte_o,
    output logic             mem_req_valid_o,
    input  logic             mem_req_ready_i,
    output logic [PA_W-1:0]  mem_addr_o,
    output logic [PTE_W-1:0] mem_wdata_o,
    input  logic             mem_rsp_valid_i,
    input  logic             mem_rsp_err_i
);

    localparam int              CNT_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    localparam logic [1:0] ACC_LOAD  = 2'd0;
    localparam logic [1:0] ACC_STORE = 2'd1;
    localparam logic [1:0] ACC_FETCH = 2'd2;
    localparam logic [1:0] ACC_ILL   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_WRITE    = 3'd2,
        S_WAIT_ACK = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t             state;
    state_t             state_next;

    logic               user;
    logic [1:0]         acc;
    logic               mxr;
    logic               sum;
    logic [PTE_W-1:0]   pte;
    logic [PA_W-1:0]    pte_addr;
    logic [PTE_W-1:0]   new_pte;
    logic [PTE_W-1:0]   rsp_pte;
    logic               allow;
    logic [3:0]         fault;
    logic [CNT_W-1:0]   cnt;

    logic [3:0]         perm_fault;
    logic               need_a;
    logic               need_d;
    logic [PTE_W-1:0]   upd_pte;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout_hit;

    logic pv, pr, pw, px, pu, pa, pd;
    assign pv = pte[0];
    assign pr = pte[1];
    assign pw = pte[2];
    assign px = pte[3];
    assign pu = pte[4];
    assign pa = pte[6];
    assign pd = pte[7];

    // First matching condition wins; order encodes fault priority.
    always_comb begin
        perm_fault = 4'd0;
        if (acc == ACC_ILL)
            perm_fault = 4'd8;
        else if (!pv || (pw && !pr) || (!pr && !px))
            perm_fault = 4'd1;
        else if ((user && !pu) || (!user && pu && (acc == ACC_FETCH || !sum)))
            perm_fault = 4'd2;
        else if (acc == ACC_LOAD && !(pr || (mxr && px)))
            perm_fault = 4'd3;
        else if (acc == ACC_STORE && !pw)
            perm_fault = 4'd4;
        else if (acc == ACC_FETCH && !px)
            perm_fault = 4'd5;
    end

    always_comb begin
        need_a     = !pa;
        need_d     = (acc == ACC_STORE) && !pd;
        upd_pte    = pte;
        upd_pte[6] = 1'b1;
        if (acc == ACC_STORE)
            upd_pte[7] = 1'b1;
    end

    assign cnt_inc     = cnt + CNT_W'(1);
    assign timeout_hit = (cnt_inc == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:
                if (req_valid_i)
                    state_next = S_CHECK;
            S_CHECK:
                if (perm_fault == 4'd0 && (need_a || need_d) && USE_HW_SET_AD)
                    state_next = S_WRITE;
                else
                    state_next = S_RESP;
            S_WRITE:
                if (mem_req_ready_i)
                    state_next = S_WAIT_ACK;
            S_WAIT_ACK:
                if (mem_rsp_valid_i || timeout_hit)
                    state_next = S_RESP;
            S_RESP:
                if (rsp_ready_i)
                    state_next = S_IDLE;
            default:
                state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            user     <= 1'b0;
            acc      <= 2'd0;
            mxr      <= 1'b0;
            sum      <= 1'b0;
            pte      <= '0;
            pte_addr <= '0;
            new_pte  <= '0;
            rsp_pte  <= '0;
            allow    <= 1'b0;
            fault    <= 4'd0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        user     <= req_user_i;
                        acc      <= req_acc_i;
                        mxr      <= req_mxr_i;
                        sum      <= req_sum_i;
                        pte      <= req_pte_i;
                        pte_addr <= req_pte_addr_i;
                    end
                end
                S_CHECK: begin
                    new_pte <= upd_pte;
                    rsp_pte <= pte;
                    allow   <= 1'b0;
                    fault   <= 4'd0;
                    if (perm_fault != 4'd0)
                        fault <= perm_fault;
                    else if (!(need_a || need_d))
                        allow <= 1'b1;
                    else if (!USE_HW_SET_AD)
                        fault <= 4'd6;
                end
                S_WRITE: begin
                    if (mem_req_ready_i)
                        cnt <= '0;
                end
                S_WAIT_ACK: begin
                    cnt <= cnt_inc;
                    // A completion arriving with the final count beats the timeout.
                    if (mem_rsp_valid_i) begin
                        if (mem_rsp_err_i) begin
                            fault <= 4'd7;
                            allow <= 1'b0;
                        end else begin
                            fault   <= 4'd0;
                            allow   <= 1'b1;
                            rsp_pte <= new_pte;
                        end
                    end else if (timeout_hit) begin
                        fault <= 4'd7;
                        allow <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o     = (state == S_IDLE);
    assign rsp_valid_o     = (state == S_RESP);
    assign rsp_allow_o     = allow;
    assign rsp_fault_o     = fault;
    assign rsp_pte_o       = rsp_pte;
    assign mem_req_valid_o = (state == S_WRITE);
    assign mem_addr_o      = pte_addr;
    assign mem_wdata_o     = new_pte;

endmodule
`default_nettype wire
